// File: rtl/apb_slave_regs_if.sv
// rtl/apb_slave_regs_if.sv - APB link between a requester and the register-block completer
interface apb_slave_regs_if;
  logic        psel_i;
  logic        penable_i;
  logic [31:0] paddr_i;
  logic        pwrite_i;
  logic [31:0] pwdata_i;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;

  modport master (
    output psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    input  pready_o, prdata_o, pslverr_o
  );

  modport slave (
    input  psel_i, penable_i, paddr_i, pwrite_i, pwdata_i,
    output pready_o, prdata_o, pslverr_o
  );
endinterface

// File: rtl/apb_slave_regs.sv
// rtl/apb_slave_regs.sv - APB completer with NUM_REGS 32-bit registers, fixed wait states, pslverr
module apb_slave_regs #(
  parameter int          NUM_REGS    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hDEAD_BE00,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                    clk,
  input  logic                    rst_n,
  apb_slave_regs_if.slave         apb,
  output logic [32*NUM_REGS-1:0]  regs_o,
  output logic [NUM_REGS-1:0]     wr_pulse_o
);
  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_dec, idx_sel;
  logic               pwrite_q, err_q, err_dec, err_sel;
  logic               setup, wr_commit;
  logic               pready_q, pslverr_q;
  logic [31:0]        prdata_q;
  logic [NUM_REGS-1:0] wr_pulse_q;
  logic [31:0]        regs_view [NUM_REGS];
  logic               unused_addr_bits;

  assign unused_addr_bits = ^apb.paddr_i[1:0];

  assign setup   = apb.psel_i & ~apb.penable_i;
  assign idx_dec = apb.paddr_i[2 +: IDX_W];
  assign err_dec = (apb.paddr_i[31:2+IDX_W] != BASE_ADDR[31:2+IDX_W])
                 | (apb.pwrite_i & (idx_dec == '0));

  // With zero wait states READY is entered straight from the setup cycle,
  // so the freshly decoded values must be used instead of the latched ones.
  assign idx_sel = (state_q == S_IDLE) ? idx_dec : idx_q;
  assign err_sel = (state_q == S_IDLE) ? err_dec : err_q;

  assign wr_commit = (state_q == S_READY) & apb.psel_i & apb.penable_i & pwrite_q & ~err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_READY : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!apb.psel_i) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_READY;
        end
      end
      S_READY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      pwrite_q   <= 1'b0;
      err_q      <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && setup) begin
        idx_q    <= idx_dec;
        pwrite_q <= apb.pwrite_i;
        err_q    <= err_dec;
      end
      pready_q   <= (state_d == S_READY);
      pslverr_q  <= (state_d == S_READY) & err_sel;
      prdata_q   <= (state_d == S_READY && !err_sel) ? regs_view[idx_sel] : '0;
      wr_pulse_q <= wr_commit ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << idx_q) : '0;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == 0) begin : g_id
      assign regs_view[i] = ID_VALUE;
    end else begin : g_rw
      logic [31:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (wr_commit && idx_q == IDX_W'(i)) begin
          r_q <= apb.pwdata_i;
        end
      end
      assign regs_view[i] = r_q;
    end
    assign regs_o[32*i +: 32] = regs_view[i];
  end

  assign apb.pready_o  = pready_q;
  assign apb.pslverr_o = pslverr_q;
  assign apb.prdata_o  = prdata_q;
  assign wr_pulse_o    = wr_pulse_q;
endmodule

// File: tb/tb_apb_slave_regs.sv
// tb/tb_apb_slave_regs.sv - directed bench: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance
module tb_apb_slave_regs;
  localparam logic [31:0] BASE = 32'hDEAD_BE00;
  localparam logic [31:0] ID   = 32'hA9B0_0001;
  localparam logic [255:0] EXP_RESET = {224'h0, ID};
  localparam logic [255:0] EXP_W3    = {128'h0, 32'h1234_5678, 64'h0, ID};
  localparam logic [255:0] EXP_B2B   = {160'h0, 32'hBBBB_2222, 32'hAAAA_1111, ID};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_slave_regs_if bus2 ();
  apb_slave_regs_if bus0 ();
  logic [255:0] regs2, regs0;
  logic [7:0]   pulse2, pulse0;

  apb_slave_regs #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .apb(bus2.slave), .regs_o(regs2), .wr_pulse_o(pulse2));
  apb_slave_regs #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .apb(bus0.slave), .regs_o(regs0), .wr_pulse_o(pulse0));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic drive(input bit fast, input bit sel, input bit en, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data);
    if (fast) begin
      bus0.psel_i = sel; bus0.penable_i = en; bus0.pwrite_i = wr;
      bus0.paddr_i = addr; bus0.pwdata_i = data;
    end else begin
      bus2.psel_i = sel; bus2.penable_i = en; bus2.pwrite_i = wr;
      bus2.paddr_i = addr; bus2.pwdata_i = data;
    end
  endtask

  task automatic bus_idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Starts just after a rising edge; returns just after the edge that ends READY,
  // with the bus left in the access phase. cycles = access cycles incl. READY, -1 on timeout.
  task automatic xfer(input bit fast, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rdata,
                      output logic err, output int cycles);
    bit done;
    done = 1'b0;
    rdata = '0;
    err = 1'b0;
    drive(fast, 1'b1, 1'b0, wr, addr, data);
    @(posedge clk); #1;
    drive(fast, 1'b1, 1'b1, wr, addr, data);
    cycles = 1;
    while (!done && cycles <= 20) begin
      @(negedge clk);
      if ((fast ? bus0.pready_o : bus2.pready_o) === 1'b1) begin
        rdata = fast ? bus0.prdata_o : bus2.prdata_o;
        err   = fast ? bus0.pslverr_o : bus2.pslverr_o;
        done  = 1'b1;
      end else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    if (!done) cycles = -1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int cy;
    @(negedge clk);
    n_cmp++; if (bus2.pready_o !== 1'b0) begin n_bad++; $display("FAIL reset_pready got %b want 0", bus2.pready_o); end
    n_cmp++; if (bus2.pslverr_o !== 1'b0 || bus2.prdata_o !== 32'h0) begin n_bad++; $display("FAIL reset_resp got err=%b data=%h want 0/0", bus2.pslverr_o, bus2.prdata_o); end
    n_cmp++; if (regs2 !== EXP_RESET || pulse2 !== 8'h00) begin n_bad++; $display("FAIL reset_regs got %h pulse %h want %h pulse 00", regs2, pulse2, EXP_RESET); end
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, BASE, 32'h0, rd, er, cy);
    bus_idle();
    n_cmp++; if (rd !== ID || er !== 1'b0) begin n_bad++; $display("FAIL read_id got %h err=%b want %h err=0", rd, er, ID); end
    n_cmp++; if (cy !== 3) begin n_bad++; $display("FAIL read_id_latency got %0d want 3", cy); end
  endtask

  task automatic test_write();
    logic [31:0] rd; logic er; int cy;
    @(posedge clk); #1;
    xfer(1'b0, 1'b1, BASE + 32'hC, 32'h1234_5678, rd, er, cy);
    bus_idle();
    n_cmp++; if (cy !== 3 || er !== 1'b0) begin n_bad++; $display("FAIL write_latency got %0d err=%b want 3 err=0", cy, er); end
    @(negedge clk);
    n_cmp++; if (regs2 !== EXP_W3) begin n_bad++; $display("FAIL write_regs got %h want %h", regs2, EXP_W3); end
    n_cmp++; if (pulse2 !== 8'b0000_1000) begin n_bad++; $display("FAIL write_pulse got %b want 00001000", pulse2); end
    @(negedge clk);
    n_cmp++; if (pulse2 !== 8'h00) begin n_bad++; $display("FAIL write_pulse_len got %b want 0", pulse2); end
  endtask

  task automatic test_read();
    logic [31:0] rd; logic er; int cy;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, BASE + 32'hC, 32'h0, rd, er, cy);
    bus_idle();
    n_cmp++; if (rd !== 32'h1234_5678 || er !== 1'b0 || cy !== 3) begin n_bad++; $display("FAIL read_r3 got %h err=%b cyc=%0d want 12345678 0 3", rd, er, cy); end
    @(negedge clk);
    n_cmp++; if (bus2.prdata_o !== 32'h0 || bus2.pready_o !== 1'b0) begin n_bad++; $display("FAIL read_after got %h rdy=%b want 0 0", bus2.prdata_o, bus2.pready_o); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int cy; logic [7:0] pulses;
    pulses = '0;
    @(posedge clk); #1;
    xfer(1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, rd, er, cy);
    bus_idle();
    n_cmp++; if (er !== 1'b1 || cy !== 3) begin n_bad++; $display("FAIL err_miss_wr got err=%b cyc=%0d want 1 3", er, cy); end
    @(negedge clk); pulses |= pulse2;
    @(posedge clk); #1;
    xfer(1'b0, 1'b1, BASE, 32'hFFFF_FFFF, rd, er, cy);
    bus_idle();
    n_cmp++; if (er !== 1'b1 || cy !== 3) begin n_bad++; $display("FAIL err_ro_wr got err=%b cyc=%0d want 1 3", er, cy); end
    @(negedge clk); pulses |= pulse2;
    n_cmp++; if (regs2 !== EXP_W3 || pulses !== 8'h00) begin n_bad++; $display("FAIL err_no_change got %h pulse %h want %h pulse 00", regs2, pulses, EXP_W3); end
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, 32'h0000_100C, 32'h0, rd, er, cy);
    bus_idle();
    n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL err_miss_rd got %h err=%b want 0 1", rd, er); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int cy; int cyc_bad;
    cyc_bad = 0;
    @(posedge clk); #1;
    xfer(1'b1, 1'b1, BASE + 32'h4, 32'hAAAA_1111, rd, er, cy); if (cy != 1 || er) cyc_bad++;
    xfer(1'b1, 1'b1, BASE + 32'h8, 32'hBBBB_2222, rd, er, cy); if (cy != 1 || er) cyc_bad++;
    xfer(1'b1, 1'b0, BASE + 32'h4, 32'h0, rd, er, cy); if (cy != 1 || er) cyc_bad++;
    n_cmp++; if (rd !== 32'hAAAA_1111) begin n_bad++; $display("FAIL b2b_rd1 got %h want aaaa1111", rd); end
    xfer(1'b1, 1'b0, BASE + 32'h8, 32'h0, rd, er, cy); if (cy != 1 || er) cyc_bad++;
    bus_idle();
    n_cmp++; if (rd !== 32'hBBBB_2222) begin n_bad++; $display("FAIL b2b_rd2 got %h want bbbb2222", rd); end
    n_cmp++; if (cyc_bad !== 0) begin n_bad++; $display("FAIL b2b_timing got %0d slow/err transfers want 0", cyc_bad); end
    @(negedge clk);
    n_cmp++; if (regs0 !== EXP_B2B) begin n_bad++; $display("FAIL b2b_regs got %h want %h", regs0, EXP_B2B); end
  endtask

  task automatic test_abort_reset();
    logic [31:0] rd; logic er; int cy; int rdy_seen; logic [7:0] pulses;
    rdy_seen = 0; pulses = '0;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, BASE + 32'h8, 32'hDEAD_0008);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b1, BASE + 32'h8, 32'hDEAD_0008);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, BASE + 32'h8, 32'hDEAD_0008);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus2.pready_o !== 1'b0) rdy_seen++;
      pulses |= pulse2;
    end
    bus_idle();
    n_cmp++; if (rdy_seen !== 0) begin n_bad++; $display("FAIL abort_pready got %0d ready cycles want 0", rdy_seen); end
    n_cmp++; if (regs2 !== EXP_W3 || pulses !== 8'h00) begin n_bad++; $display("FAIL abort_nowrite got %h pulse %h want %h pulse 00", regs2, pulses, EXP_W3); end
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, BASE + 32'hC, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, BASE + 32'hC, 32'h0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (regs2 !== EXP_RESET || regs0 !== EXP_RESET) begin n_bad++; $display("FAIL async_rst_regs got %h / %h want %h", regs2, regs0, EXP_RESET); end
    n_cmp++; if (bus2.pready_o !== 1'b0 || bus2.pslverr_o !== 1'b0 || bus2.prdata_o !== 32'h0 || pulse2 !== 8'h00) begin n_bad++; $display("FAIL async_rst_outs got rdy=%b err=%b data=%h pulse=%h want 0", bus2.pready_o, bus2.pslverr_o, bus2.prdata_o, pulse2); end
    bus_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 1'b0, BASE + 32'hC, 32'h0, rd, er, cy);
    bus_idle();
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0 || cy !== 3) begin n_bad++; $display("FAIL post_rst_read got %h err=%b cyc=%0d want 0 0 3", rd, er, cy); end
  endtask

  initial begin
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_write();
    test_read();
    test_errors();
    test_back_to_back();
    test_abort_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
